reg_skid: RTL and testbench
===========================

# reg_skid

Two-entry elastic pipeline register (skid buffer). It is the receiving-side counterpart of the plain free-running `REG` stage. It accepts data from an upstream producer over a valid/ready handshake and presents it downstream, so the consumer can apply backpressure without losing a word. The block breaks the ready path combinationally: `IN_READY` depends only on registered state, never on `OUT_READY`. It is used between scheduler pipeline stages wherever the consumer can stall.

## Interface
- `NUM`, default 16: data width in bits.

Ports:
- `clk`: input, 1 bit. Clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset, asynchronous, active-high.
- `IN_VALID`: input, 1 bit. Upstream word valid.
- `IN_READY`: output, 1 bit. Block can accept a word this cycle.
- `IN`: input, `NUM` bits. Upstream data word.
- `OUT_VALID`: output, 1 bit. `OUT` holds a valid word.
- `OUT_READY`: input, 1 bit. Downstream accepts `OUT` this cycle.
- `OUT`: output, `NUM` bits. Head data word, driven directly from the main register.
- `LEVEL`: output, 2 bits. Number of words held (0, 1 or 2).

## Operation
- Storage: main register `M` (drives `OUT`) and skid register `S`.
- push = `IN_VALID & IN_READY`; pop = `OUT_VALID & OUT_READY`.
- States and outputs:
  - EMPTY: `LEVEL`=0, `OUT_VALID`=0, `IN_READY`=1.
  - ONE: `LEVEL`=1, `OUT_VALID`=1, `IN_READY`=1.
  - TWO: `LEVEL`=2, `OUT_VALID`=1, `IN_READY`=0.
- Transitions:
  - EMPTY, push: `M`<=`IN`, go to ONE. No push: stay.
  - ONE, push & pop: `M`<=`IN`, stay in ONE.
  - ONE, push & !pop: `S`<=`IN`, go to TWO. `M` is unchanged.
  - ONE, !push & pop: go to EMPTY. `M` keeps its stale value.
  - ONE, neither: stay.
  - TWO, pop: `M`<=`S`, go to ONE. No push is possible because `IN_READY`=0.
  - TWO, !pop: stay. `M` and `S` are unchanged.
- Order: strict FIFO. The word in `S` is always younger than the word in `M`.
- `IN_VALID` while `IN_READY`=0 is not a push. `IN` is ignored and no state changes.
- `OUT_READY` while `OUT_VALID`=0 is not a pop and has no effect.
- Data is passed bit-exact. No arithmetic is performed on it.
- `IN_READY`, `OUT_VALID` and `LEVEL` decode from the state register only; there is no combinational path from any input to them.

## Timing
- Reset (async assert, sync release via `clk`):
  - State = EMPTY, `M`=0, `S`=0.
  - Outputs: `OUT`=0, `OUT_VALID`=0, `LEVEL`=0.
  - `IN_READY` is forced to 0 while `rst` is high. It returns to 1 combinationally once `rst` deasserts, with state EMPTY.
- Reset mid-operation discards all held words immediately. No pop is reported for them.
- Latency: a word pushed at edge k is visible on `OUT` with `OUT_VALID`=1 after edge k. That is 1 cycle for EMPTY to ONE.
- Throughput: 1 word/cycle sustained while `OUT_READY`=1 (state stays in ONE).
- Backpressure:
  - `OUT_READY` low for one cycle in ONE with a push moves the block to TWO.
  - Upstream then sees `IN_READY`=0 starting the following cycle.
  - The word offered in that cycle is already captured in `S`, so nothing is lost.
- Stability rule: while `OUT_VALID`=1 and `OUT_READY`=0, `OUT` must not change.
- Full boundary: in TWO, a simultaneous `IN_VALID` and pop accepts nothing from upstream that cycle. `IN_READY` goes to 1 the next cycle.
- Empty boundary: in EMPTY with `OUT_READY`=1, nothing happens.

## Test plan
- Reset: assert `rst` mid-stream while in TWO. Required: `OUT_VALID`=0, `IN_READY`=0, `LEVEL`=0, `OUT`=0 without waiting for a clock edge. After release, `IN_READY`=1.
- Streaming:
  - Stimulus: `OUT_READY`=1, push 0x0001..0x0010 on consecutive cycles.
  - Required: `OUT` shows 0x0001..0x0010 in order, each one cycle after its push. `LEVEL` stays at 1 and there are no bubbles.
- Single stall:
  - Stimulus: while streaming 0xA000, 0xA001, 0xA002, drop `OUT_READY` for the cycle `OUT`=0xA000.
  - Required: `LEVEL`=2 and `IN_READY`=0 the next cycle. `OUT` is held at 0xA000. Output order is 0xA000, 0xA001, 0xA002 with no loss or duplication.
- Long stall:
  - Stimulus: hold `OUT_READY`=0 for 10 cycles while `IN_VALID`=1 with changing `IN`.
  - Required: exactly 2 words are accepted and `IN_READY`=0 for the remainder. `OUT` is stable. On release, both accepted words drain in order.
- Empty drain:
  - Stimulus: push 0x5A5A, then `OUT_READY`=1 with `IN_VALID`=0.
  - Required: 0x5A5A is popped once, then `OUT_VALID`=0 and `LEVEL`=0. Extra `OUT_READY` cycles have no effect.
- Random: randomized `IN_VALID`/`OUT_READY` with 50/50 density over 10k cycles, checked against a scoreboard. Required: no loss, no reorder, no duplication. `IN_READY` must never equal 1 while `LEVEL`=2.

Source files
------------

// File: rtl/reg_skid_if.sv
// Valid/ready bus between an upstream producer, the reg_skid stage and its consumer.
// The producer/testbench side takes the master modport, and the skid stage takes the slave modport.
interface reg_skid_if #(
  parameter int NUM = 16
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [NUM-1:0] IN;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [NUM-1:0] OUT;
  logic [1:0]     LEVEL;

  modport master (
    output IN_VALID,
    output IN,
    output OUT_READY,
    input  IN_READY,
    input  OUT_VALID,
    input  OUT,
    input  LEVEL
  );

  modport slave (
    input  IN_VALID,
    input  IN,
    input  OUT_READY,
    output IN_READY,
    output OUT_VALID,
    output OUT,
    output LEVEL
  );
endinterface

// File: rtl/reg_skid.sv
// Two-entry skid buffer: main register M drives OUT, and skid register S absorbs one word on a stall.
// Handshake outputs come from registers only, so IN_READY never depends on OUT_READY.
module reg_skid #(
  parameter int NUM = 16
) (
  input  logic     clk,
  input  logic     rst,
  reg_skid_if.slave bus
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t         state_q;
  logic [NUM-1:0] m_q;
  logic [NUM-1:0] s_q;
  logic           out_valid_q;
  logic           in_ready_q;
  logic [1:0]     level_q;

  logic push;
  logic pop;

  assign push = bus.IN_VALID & in_ready_q;
  assign pop  = out_valid_q & bus.OUT_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      level_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            m_q         <= bus.IN;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            level_q     <= 2'd1;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b11: m_q <= bus.IN;
            2'b10: begin
              // Consumer stalled: park the younger word in S and stop upstream.
              s_q         <= bus.IN;
              state_q     <= ST_TWO;
              in_ready_q  <= 1'b0;
              level_q     <= 2'd2;
            end
            2'b01: begin
              // M keeps its stale value; OUT_VALID low marks it as dead.
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
              level_q     <= 2'd0;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (pop) begin
            m_q        <= s_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
            level_q    <= 2'd1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          level_q     <= 2'd0;
        end
      endcase
    end
  end

  // Held off while rst is high; returns as soon as reset releases with state already EMPTY.
  assign bus.IN_READY  = in_ready_q & ~rst;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT       = m_q;
  assign bus.LEVEL     = level_q;
endmodule

// File: tb/tb_reg_skid.sv
// Self-checking bench for reg_skid: a queue of expected words is filled on model pushes and
// compared against OUT whenever the model holds data.
module tb_reg_skid;
  localparam int NUM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_skid_if #(.NUM(NUM)) bus ();

  reg_skid #(.NUM(NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [NUM-1:0] sb[$];

  task automatic drive(input logic iv, input logic [NUM-1:0] din, input logic ordy);
    bus.IN_VALID  = iv;
    bus.IN        = din;
    bus.OUT_READY = ordy;
  endtask

  // Advances the reference model across the next rising edge and re-aligns to edge+1.
  task automatic model_edge();
    bit push_m;
    bit pop_m;
    push_m = bus.IN_VALID && (sb.size() < 2);
    pop_m  = (sb.size() > 0) && bus.OUT_READY;
    if (pop_m) begin
      $display("pop  data=%h level=%0d", sb[0], sb.size());
      void'(sb.pop_front());
    end
    if (push_m) sb.push_back(bus.IN);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.IN_READY); end
    checks++; if (bus.LEVEL !== 2'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", bus.LEVEL); end
    checks++; if (bus.OUT !== '0) begin errors++; $display("FAIL rst_out got=%h exp=0000", bus.OUT); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", bus.IN_READY); end
    checks++; if (bus.LEVEL !== 2'd0) begin errors++; $display("FAIL rel_level got=%0d exp=0", bus.LEVEL); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) drive(1'b1, NUM'(i), 1'b1);
      else         drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (i > 1) begin
        checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, bus.OUT_VALID); end
        checks++; if (bus.OUT !== NUM'(i - 1)) begin errors++; $display("FAIL stream_out i=%0d got=%h exp=%h", i, bus.OUT, NUM'(i - 1)); end
        checks++; if (bus.LEVEL !== 2'd1) begin errors++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, bus.LEVEL); end
      end
      checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, bus.IN_READY); end
      model_edge();
    end
    @(negedge clk);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL stream_end_valid got=%b exp=0", bus.OUT_VALID); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_stall();
    logic           tv_iv[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [NUM-1:0] tv_din[6]  = '{16'hA000, 16'hA001, 16'hA002, 16'hA002, 16'h0000, 16'h0000};
    logic           tv_ordy[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      drive(tv_iv[c], tv_din[c], tv_ordy[c]);
      @(negedge clk);
      checks++; if (bus.LEVEL !== 2'(sb.size())) begin errors++; $display("FAIL stall_level c=%0d got=%0d exp=%0d", c, bus.LEVEL, sb.size()); end
      checks++; if (bus.IN_READY !== (sb.size() < 2)) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b exp=%b", c, bus.IN_READY, sb.size() < 2); end
      if (sb.size() > 0) begin
        checks++; if (bus.OUT !== sb[0]) begin errors++; $display("FAIL stall_out c=%0d got=%h exp=%h", c, bus.OUT, sb[0]); end
      end
      if (c == 2) begin
        checks++; if (bus.OUT !== 16'hA000 || bus.LEVEL !== 2'd2 || bus.IN_READY !== 1'b0) begin
          errors++; $display("FAIL stall_hold got=%h/%0d/%b exp=a000/2/0", bus.OUT, bus.LEVEL, bus.IN_READY);
        end
      end
      if (c == 3) begin
        checks++; if (bus.OUT !== 16'hA001) begin errors++; $display("FAIL stall_second got=%h exp=a001", bus.OUT); end
      end
      if (c == 4) begin
        checks++; if (bus.OUT !== 16'hA002) begin errors++; $display("FAIL stall_third got=%h exp=a002", bus.OUT); end
      end
      if (c == 5) begin
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL stall_empty got=%b exp=0", bus.OUT_VALID); end
      end
      model_edge();
    end
  endtask

  task automatic test_long_stall();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, NUM'(16'hB000 + i), 1'b0);
      @(negedge clk);
      if (i >= 1) begin
        checks++; if (bus.OUT !== 16'hB000) begin errors++; $display("FAIL long_out i=%0d got=%h exp=b000", i, bus.OUT); end
      end
      if (i >= 2) begin
        checks++; if (bus.IN_READY !== 1'b0 || bus.LEVEL !== 2'd2) begin
          errors++; $display("FAIL long_full i=%0d got=%b/%0d exp=0/2", i, bus.IN_READY, bus.LEVEL);
        end
      end
      model_edge();
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    checks++; if (bus.OUT !== 16'hB000 || bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL long_drain0 got=%h/%b exp=b000/1", bus.OUT, bus.OUT_VALID); end
    model_edge();
    @(negedge clk);
    checks++; if (bus.OUT !== 16'hB001 || bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL long_drain1 got=%h/%b exp=b001/1", bus.OUT, bus.OUT_VALID); end
    model_edge();
    @(negedge clk);
    checks++; if (bus.OUT_VALID !== 1'b0 || bus.LEVEL !== 2'd0) begin errors++; $display("FAIL long_drained got=%b/%0d exp=0/0", bus.OUT_VALID, bus.LEVEL); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty_drain();
    drive(1'b1, 16'h5A5A, 1'b0);
    model_edge();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    checks++; if (bus.OUT !== 16'h5A5A || bus.OUT_VALID !== 1'b1 || bus.LEVEL !== 2'd1) begin
      errors++; $display("FAIL drain_head got=%h/%b/%0d exp=5a5a/1/1", bus.OUT, bus.OUT_VALID, bus.LEVEL);
    end
    model_edge();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.OUT_VALID !== 1'b0 || bus.LEVEL !== 2'd0 || bus.IN_READY !== 1'b1) begin
        errors++; $display("FAIL drain_idle i=%0d got=%b/%0d/%b exp=0/0/1", i, bus.OUT_VALID, bus.LEVEL, bus.IN_READY);
      end
      model_edge();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 16'hC000, 1'b0);
    model_edge();
    drive(1'b1, 16'hC001, 1'b0);
    model_edge();
    @(negedge clk);
    checks++; if (bus.LEVEL !== 2'd2) begin errors++; $display("FAIL mid_pre_level got=%0d exp=2", bus.LEVEL); end
    rst = 1'b1;
    #1;
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL mid_in_ready got=%b exp=0", bus.IN_READY); end
    checks++; if (bus.LEVEL !== 2'd0) begin errors++; $display("FAIL mid_level got=%0d exp=0", bus.LEVEL); end
    checks++; if (bus.OUT !== '0) begin errors++; $display("FAIL mid_out got=%h exp=0000", bus.OUT); end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    #1;
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL mid_release got=%b exp=1", bus.IN_READY); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      drive(1'($urandom_range(0, 1)), r[NUM-1:0], 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++; if (bus.LEVEL !== 2'(sb.size())) begin errors++; $display("FAIL rand_level i=%0d got=%0d exp=%0d", i, bus.LEVEL, sb.size()); end
      checks++; if (bus.OUT_VALID !== (sb.size() > 0)) begin errors++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, bus.OUT_VALID, sb.size() > 0); end
      checks++; if (bus.IN_READY !== (sb.size() < 2)) begin errors++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, bus.IN_READY, sb.size() < 2); end
      checks++; if (bus.IN_READY === 1'b1 && bus.LEVEL === 2'd2) begin errors++; $display("FAIL rand_full_ready i=%0d got=1 exp=0", i); end
      if (sb.size() > 0) begin
        checks++; if (bus.OUT !== sb[0]) begin errors++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, bus.OUT, sb[0]); end
      end
      model_edge();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (sb.size() > 0) begin
        checks++; if (bus.OUT !== sb[0]) begin errors++; $display("FAIL rand_tail i=%0d got=%h exp=%h", i, bus.OUT, sb[0]); end
      end
      model_edge();
    end
    @(negedge clk);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rand_final got=%b exp=0", bus.OUT_VALID); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_streaming();
    test_single_stall();
    test_long_stall();
    test_empty_drain();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
